jtag_master: RTL and testbench
==============================

# jtag_master

JTAG initiator that generates TCK/TMS/TDI and samples TDO. It can drive an external TAP, or the on-board JTAG listener in loopback. It accepts one scan command at a time over a valid/ready handshake. A command either resets the TAP to Test-Logic-Reset and parks it in Run-Test/Idle, or runs a complete IR or DR scan from Run-Test/Idle back to Run-Test/Idle. Captured TDO bits are returned on a single-cycle response strobe, so debug firmware can step and read a target TAP from the FPGA.

## Interface
Parameters:
- CLK_DIV, default 4: sys_clk cycles per TCK half-period. Legal values are 2 or more.
- MAX_LEN, default 32: width of the scan data and response buses.

Ports:
- sys_clk  in  1  system clock. This is the block's only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_reset  in  1  1 = TAP reset command; cmd_ir, cmd_len and cmd_data are ignored.
- cmd_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  6  number of bits to scan. 0 or any value above MAX_LEN is treated as MAX_LEN.
- cmd_data  in  MAX_LEN  TDI bits, shifted out LSB first.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_data  out  MAX_LEN  captured TDO bits, LSB first; bits at or above len are 0.
- busy  out  1  equal to ~cmd_ready.
- jtag_tck  out  1  generated TCK.
- jtag_tms  out  1  TMS.
- jtag_tdi  out  1  TDI.
- jtag_tdo  in  1  TDO from target, synchronous to TCK.

## Operation
- Reset values: jtag_tck=0, jtag_tms=0, jtag_tdi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0.
- Handshake: a command is accepted on a sys_clk edge with cmd_valid & cmd_ready. All command fields are registered at acceptance. cmd_ready drops on the next cycle.
- TCK cycle structure:
  - TMS/TDI change only in the sys_clk cycle where TCK goes low (or at the start of the first TCK cycle).
  - TCK stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - jtag_tdo is registered on the sys_clk edge that drives TCK high.
- States: IDLE, TLR, PRE, SHIFT, POST, DONE.
- IDLE: TCK is low and TMS is 0. TCK never toggles while idle.
- TLR (cmd_reset): 5 TCK cycles with TMS=1, then 1 cycle with TMS=0. Then DONE with rsp_data=0.
- PRE, DR scan: TMS sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- PRE, IR scan: TMS sequence 1,1,0,0.
- SHIFT: len TCK cycles; cycle i drives jtag_tdi=cmd_data[i].
  - TMS=0 for cycles 0..len-2; TMS=1 on cycle len-1 (exit to Exit1).
  - The TDO sample of cycle i is stored in rsp_data[i].
- POST: TMS sequence 1,0 (Update, then Run-Test/Idle).
- DONE: rsp_valid=1 for exactly one cycle. rsp_data holds its value until the next command completes. cmd_ready returns to 1 on the following cycle.
- TDI outside SHIFT is 0. TDI and TMS return to 0 when IDLE is re-entered.
- A cmd_valid pulse while busy is ignored and does not queue.
- An asynchronous reset during any state returns all outputs to reset values immediately.
  - No partial response is issued.
  - The TAP is left wherever it was; software must issue cmd_reset afterwards.

## Timing
- TCK cycle counts:
  - TAP reset: 6.
  - DR scan: len+5.
  - IR scan: len+6.
- rsp_valid asserts exactly 2*CLK_DIV*N sys_clk cycles after the accept edge, where N is the TCK count. Example: DR scan, len=8, CLK_DIV=4 → 104 cycles.
- Back-to-back throughput: the next accept occurs 2 cycles after rsp_valid at the earliest.
- TCK frequency is sys_clk/(2*CLK_DIV), with a 50 % duty cycle.
- The first TCK rising edge occurs CLK_DIV cycles after the TMS/TDI update.
- TDO is sampled 1 sys_clk after the TCK falling edge plus CLK_DIV-1 cycles of settling.

## Test plan
- Reset: hold sys_rst_n=0 → tck=0, tms=0, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0.
- cmd_reset=1 → TMS over 6 TCK rising edges is 1,1,1,1,1,0 → behavioural TAP model in Run-Test/Idle; rsp_valid after 48 cycles (CLK_DIV=4); rsp_data=0.
- DR scan, len=8, cmd_data=0x3C, TAP model 8-bit DR preloaded 0xA5:
  - rsp_data=0x000000A5 and model DR=0x3C.
  - TMS trace is 1,0,0,0×7,1,1,0.
  - rsp_valid at cycle 104.
- IR scan, len=4, cmd_data=0xE, model IR capture value 0x1 → rsp_data=0x1, model IR=0xE, TMS trace 1,1,0,0,0,0,0,1,1,0, total 10 TCK.
- Edge cases:
  - cmd_len=0 with DR=0xDEADBEEF preload → 32 bits shifted, rsp_data=0xDEADBEEF.
  - A cmd_valid pulse mid-scan is ignored and no second rsp_valid appears.
- Assert sys_rst_n=0 midway through a len=16 SHIFT → outputs return to reset values within the same cycle, no rsp_valid. A subsequent cmd_reset restores the model to Run-Test/Idle.

Source files
------------

// File: rtl/jtag_master.sv
`timescale 1ns/1ps
// JTAG initiator: runs one TAP reset or complete IR/DR scan per command and
// returns the captured TDO bits on a single-cycle response strobe.
module jtag_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_reset,
  input  logic               cmd_ir,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TLR   = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int            PW      = (CLK_DIV < 2) ? 2 : $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_FALL = PW'(2 * CLK_DIV - 1);
  localparam logic [6:0]    LEN_MAX = 7'(MAX_LEN);

  logic [2:0]         state_q, state_d;
  logic [6:0]         step_q, step_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic [6:0]         len_q, len_d;
  logic               ir_q, ir_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;

  logic [6:0]         cmd_len_eff;
  logic [MAX_LEN-1:0] tdo_vec;
  logic [2:0]         adv_state;
  logic [6:0]         adv_step;

  // TMS for a given TCK cycle: every state sequence ends on a 0 so the TAP parks in Run-Test/Idle.
  function automatic logic tms_for(input logic [2:0] st, input logic [6:0] stp,
                                   input logic ir, input logic [6:0] len);
    case (st)
      S_TLR:   tms_for = (stp < 7'd5);
      S_PRE:   tms_for = ir ? (stp < 7'd2) : (stp == 7'd0);
      S_SHIFT: tms_for = (stp == len - 7'd1);
      S_POST:  tms_for = (stp == 7'd0);
      default: tms_for = 1'b0;
    endcase
  endfunction

  function automatic logic tdi_for(input logic [2:0] st, input logic [6:0] stp,
                                   input logic [MAX_LEN-1:0] data);
    logic [MAX_LEN-1:0] sh;
    sh = data >> stp;
    return (st == S_SHIFT) && sh[0];
  endfunction

  assign cmd_len_eff = ((cmd_len == 6'd0) || ({1'b0, cmd_len} > LEN_MAX)) ? LEN_MAX
                                                                           : {1'b0, cmd_len};
  assign tdo_vec     = MAX_LEN'(jtag_tdo);

  // Where the sequencer goes at the end of the current TCK cycle.
  always_comb begin
    adv_state = state_q;
    adv_step  = step_q + 7'd1;
    case (state_q)
      S_TLR:   if (step_q == 7'd5) begin
                 adv_state = S_DONE;
                 adv_step  = '0;
               end
      S_PRE:   if (step_q == (ir_q ? 7'd3 : 7'd2)) begin
                 adv_state = S_SHIFT;
                 adv_step  = '0;
               end
      S_SHIFT: if (step_q == len_q - 7'd1) begin
                 adv_state = S_POST;
                 adv_step  = '0;
               end
      S_POST:  if (step_q == 7'd1) begin
                 adv_state = S_DONE;
                 adv_step  = '0;
               end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = phase_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    rsp_d   = rsp_q;
    len_d   = len_q;
    ir_d    = ir_q;
    data_d  = data_q;
    cap_d   = cap_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Both the reset and the scan sequences open with TMS=1.
          state_d = cmd_reset ? S_TLR : S_PRE;
          step_d  = '0;
          phase_d = '0;
          tck_d   = 1'b0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          len_d   = cmd_len_eff;
          ir_d    = cmd_ir;
          data_d  = cmd_data;
          cap_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tck_d   = 1'b0;
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
      end
      default: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_RISE) begin
          tck_d = 1'b1;
          if (state_q == S_SHIFT) cap_d = cap_q | (tdo_vec << step_q);
        end else if (phase_q == PH_FALL) begin
          tck_d   = 1'b0;
          phase_d = '0;
          state_d = adv_state;
          step_d  = adv_step;
          tms_d   = tms_for(adv_state, adv_step, ir_q, len_q);
          tdi_d   = tdi_for(adv_state, adv_step, data_q);
          if (adv_state == S_DONE) rsp_d = cap_q;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      phase_q <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b0;
      tdi_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      rsp_q   <= rsp_d;
    end
  end

  // Command fields and the capture buffer are always reloaded before use.
  always_ff @(posedge sys_clk) begin
    len_q  <= len_d;
    ir_q   <= ir_d;
    data_q <= data_d;
    cap_q  <= cap_d;
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
`timescale 1ns/1ps
// Directed bench for jtag_master driving a behavioural IEEE 1149.1 TAP model.
module tb_jtag_master;
  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 32;
  localparam int NVEC    = 7;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_valid, cmd_ready, cmd_reset, cmd_ir;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data, rsp_data;
  logic        rsp_valid, busy, jtag_tck, jtag_tms, jtag_tdi;
  logic        jtag_tdo = 1'b0;

  always #5 sys_clk = ~sys_clk;

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_reset (cmd_reset),
    .cmd_ir    (cmd_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .jtag_tck  (jtag_tck),
    .jtag_tms  (jtag_tms),
    .jtag_tdi  (jtag_tdi),
    .jtag_tdo  (jtag_tdo)
  );

  // Behavioural TAP: state moves on TCK rise, TDO changes on TCK fall.
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
  } tap_e;

  tap_e        tap = T_TLR;
  logic [31:0] dr_sh = '0, dr_reg = '0, ir_sh = '0, ir_reg = '0;
  logic [31:0] dr_cap_val = '0, ir_cap_val = 32'h1;
  int          dr_len = 8, ir_len = 4;
  logic        tms_log[$];
  int          rsp_cnt = 0;

  always @(posedge jtag_tck) begin
    tms_log.push_back(jtag_tms);
    case (tap)
      T_TLR:   tap <= jtag_tms ? T_TLR : T_RTI;
      T_RTI:   tap <= jtag_tms ? T_SELDR : T_RTI;
      T_SELDR: tap <= jtag_tms ? T_SELIR : T_CAPDR;
      T_CAPDR: begin dr_sh <= dr_cap_val; tap <= jtag_tms ? T_EX1DR : T_SHDR; end
      T_SHDR:  begin
        dr_sh <= (dr_sh >> 1) | (32'(jtag_tdi) << (dr_len - 1));
        tap   <= jtag_tms ? T_EX1DR : T_SHDR;
      end
      T_EX1DR: tap <= jtag_tms ? T_UPDR : T_PADR;
      T_PADR:  tap <= jtag_tms ? T_EX2DR : T_PADR;
      T_EX2DR: tap <= jtag_tms ? T_UPDR : T_SHDR;
      T_UPDR:  begin dr_reg <= dr_sh; tap <= jtag_tms ? T_SELDR : T_RTI; end
      T_SELIR: tap <= jtag_tms ? T_TLR : T_CAPIR;
      T_CAPIR: begin ir_sh <= ir_cap_val; tap <= jtag_tms ? T_EX1IR : T_SHIR; end
      T_SHIR:  begin
        ir_sh <= (ir_sh >> 1) | (32'(jtag_tdi) << (ir_len - 1));
        tap   <= jtag_tms ? T_EX1IR : T_SHIR;
      end
      T_EX1IR: tap <= jtag_tms ? T_UPIR : T_PAIR;
      T_PAIR:  tap <= jtag_tms ? T_EX2IR : T_PAIR;
      T_EX2IR: tap <= jtag_tms ? T_UPIR : T_SHIR;
      T_UPIR:  begin ir_reg <= ir_sh; tap <= jtag_tms ? T_SELDR : T_RTI; end
      default: tap <= T_TLR;
    endcase
  end

  always @(negedge jtag_tck)
    jtag_tdo <= (tap == T_SHDR) ? dr_sh[0] : (tap == T_SHIR) ? ir_sh[0] : 1'b0;

  always @(posedge sys_clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [5:0]  len;
    logic [31:0] data;
    logic [31:0] cap;
    int          reg_len;
    logic [31:0] exp_rsp;
    int          exp_tck;
    int          exp_cyc;
    int          reg_kind;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t  vecs [NVEC];
  string exp_tms [NVEC];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic issue(input logic rst, input logic ir, input logic [5:0] len,
                       input logic [31:0] data);
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_reset = rst;
    cmd_ir    = ir;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge sys_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int start, output int cycles);
    cycles = start;
    while (!rsp_valid && cycles < 2000) begin
      @(posedge sys_clk);
      #1;
      cycles++;
    end
    chk({name, "_rsp_timeout"}, 64'(cycles >= 2000), 64'd0);
  endtask

  task automatic apply_vec(input int i);
    vec_t  v;
    int    cyc, base, rc0;
    string got, tag;
    v   = vecs[i];
    tag = $sformatf("v%0d", i);
    if (v.ir) begin ir_cap_val = v.cap; ir_len = v.reg_len; end
    else if (!v.rst) begin dr_cap_val = v.cap; dr_len = v.reg_len; end
    base = tms_log.size();
    rc0  = rsp_cnt;
    issue(v.rst, v.ir, v.len, v.data);
    wait_rsp(tag, 0, cyc);
    chk({tag, "_cycles"}, 64'(cyc), 64'(v.exp_cyc));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(v.exp_rsp));
    chk({tag, "_tck_count"}, 64'(tms_log.size() - base), 64'(v.exp_tck));
    got = "";
    for (int k = base; k < tms_log.size(); k++) got = $sformatf("%s%0d", got, tms_log[k]);
    chk_str({tag, "_tms"}, got, exp_tms[i]);
    chk({tag, "_tap_state"}, 64'(tap), 64'(T_RTI));
    if (v.reg_kind == 1) chk({tag, "_dr_reg"}, 64'(dr_reg), 64'(v.exp_reg));
    else if (v.reg_kind == 2) chk({tag, "_ir_reg"}, 64'(ir_reg), 64'(v.exp_reg));
    @(posedge sys_clk);
    #1;
    chk({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_hold"}, 64'(rsp_data), 64'(v.exp_rsp));
    chk({tag, "_rsp_count"}, 64'(rsp_cnt - rc0), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tck"}, 64'(jtag_tck), 64'd0);
    chk({tag, "_tms"}, 64'(jtag_tms), 64'd0);
    chk({tag, "_tdi"}, 64'(jtag_tdi), 64'd0);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, base, rc0;

    //         rst   ir    len    data           cap            rlen rsp            tck cyc  kind reg
    vecs[0] = '{1'b1, 1'b0, 6'd0,  32'h0,         32'h0,         0,  32'h0,         6,  48,  0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 6'd8,  32'h3C,        32'hA5,        8,  32'hA5,        13, 104, 1, 32'h3C};
    vecs[2] = '{1'b0, 1'b1, 6'd4,  32'hE,         32'h1,         4,  32'h1,         10, 80,  2, 32'hE};
    vecs[3] = '{1'b0, 1'b0, 6'd0,  32'h12345678,  32'hDEADBEEF,  32, 32'hDEADBEEF,  37, 296, 1, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 6'd40, 32'hFFFF0000,  32'h0F0F0F0F,  32, 32'h0F0F0F0F,  37, 296, 1, 32'hFFFF0000};
    vecs[5] = '{1'b0, 1'b0, 6'd5,  32'hFFFFFFF5,  32'h0A,        5,  32'h0A,        10, 80,  1, 32'h15};
    vecs[6] = '{1'b0, 1'b0, 6'd1,  32'h1,         32'h0,         1,  32'h0,         6,  48,  1, 32'h1};
    exp_tms[0] = "111110";
    exp_tms[1] = "1000000000110";
    exp_tms[2] = "1100000110";
    exp_tms[3] = "100";
    for (int k = 0; k < 31; k++) exp_tms[3] = $sformatf("%s0", exp_tms[3]);
    exp_tms[3] = $sformatf("%s110", exp_tms[3]);
    exp_tms[4] = exp_tms[3];
    exp_tms[5] = "1000000110";
    exp_tms[6] = "100110";

    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_reset = 1'b0;
    cmd_ir    = 1'b0;
    cmd_len   = '0;
    cmd_data  = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    base = tms_log.size();
    repeat (20) @(posedge sys_clk);
    #1;
    chk("idle_no_tck", 64'(tms_log.size() - base), 64'd0);
    chk("idle_tms", 64'(jtag_tms), 64'd0);

    for (int i = 0; i < NVEC; i++) apply_vec(i);

    // A second command offered mid-scan must be dropped, not queued.
    dr_cap_val = 32'h5A;
    dr_len     = 8;
    rc0        = rsp_cnt;
    issue(1'b0, 1'b0, 6'd8, 32'h96);
    cyc = 0;
    while (!jtag_tck && cyc < 50) begin
      @(posedge sys_clk);
      #1;
      cyc++;
    end
    chk("first_rise_delay", 64'(cyc), 64'(CLK_DIV));
    chk("first_rise_tms", 64'(jtag_tms), 64'd1);
    repeat (20) @(posedge sys_clk);
    #1;
    cyc += 20;
    chk("busy_mid_scan", 64'(busy), 64'd1);
    chk("ready_mid_scan", 64'(cmd_ready), 64'd0);
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_reset = 1'b1;
    @(posedge sys_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_reset = 1'b0;
    cyc += 1;
    wait_rsp("ignore", cyc, cyc);
    chk("ignore_cycles", 64'(cyc), 64'd104);
    chk("ignore_rsp_data", 64'(rsp_data), 64'h5A);
    repeat (300) @(posedge sys_clk);
    #1;
    chk("ignore_single_rsp", 64'(rsp_cnt - rc0), 64'd1);
    chk("ignore_dr_reg", 64'(dr_reg), 64'h96);
    chk("ignore_idle_ready", 64'(cmd_ready), 64'd1);
    chk("ignore_idle_tdi", 64'(jtag_tdi), 64'd0);

    // Asynchronous reset in the middle of a 16-bit shift, while TCK is high.
    dr_cap_val = 32'hBEEF;
    dr_len     = 16;
    rc0        = rsp_cnt;
    issue(1'b0, 1'b0, 6'd16, 32'h1234);
    repeat (94) @(posedge sys_clk);
    #3;
    chk("arst_pre_busy", 64'(busy), 64'd1);
    chk("arst_pre_tck", 64'(jtag_tck), 64'd1);
    chk("arst_pre_tap", 64'(tap), 64'(T_SHDR));
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    base = tms_log.size();
    repeat (5) @(posedge sys_clk);
    #1;
    chk("arst_no_rsp", 64'(rsp_cnt - rc0), 64'd0);
    chk("arst_no_tck", 64'(tms_log.size() - base), 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (300) @(posedge sys_clk);
    #1;
    chk("arst_no_late_rsp", 64'(rsp_cnt - rc0), 64'd0);
    apply_vec(0);
    apply_vec(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
